control_sequencer: RTL and testbench

Hardwired control unit for the Mini SRC single-bus CPU. It fetches each instruction through the shared bus, decodes the opcode held in IR, and steps through T-states. In each state it drives the bus-source strobes, register-load strobes, register-select lines (Gra/Grb/Grc/Rin/Rout/BAout), ALU operation and memory read/write. It sits directly upstream of the datapath (encoder, register file, ALU, MDR/MAR) and consumes IR and the CON flip-flop output.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/control_sequencer_if.sv | 25 ++
 rtl/opcode_class_decode.sv | 30 +++
 rtl/control_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode map, state/class enums and strobe bit indices for the control sequencer
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_HALTED, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7
   } state_t;

   typedef enum logic [4:0] {
      CL_LD, CL_LDI, CL_ST, CL_ALU, CL_IMM, CL_MULDIV, CL_NEGNOT, CL_BR,
      CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
   } op_class_t;

   // bus_drive bit positions
   localparam int BD_PC     = 7;
   localparam int BD_ZHI    = 6;
   localparam int BD_ZLO    = 5;
   localparam int BD_MDR    = 4;
   localparam int BD_HI     = 3;
   localparam int BD_LO     = 2;
   localparam int BD_INPORT = 1;
   localparam int BD_C      = 0;

   // reg_sel bit positions
   localparam int RS_GRA   = 5;
   localparam int RS_GRB   = 4;
   localparam int RS_GRC   = 3;
   localparam int RS_RIN   = 2;
   localparam int RS_ROUT  = 1;
   localparam int RS_BAOUT = 0;

   // reg_load bit positions (bit 0 is a spare that stays low)
   localparam int RL_MARIN     = 12;
   localparam int RL_PCIN      = 11;
   localparam int RL_MDRIN     = 10;
   localparam int RL_IRIN      = 9;
   localparam int RL_YIN       = 8;
   localparam int RL_ZIN       = 7;
   localparam int RL_HIIN      = 6;
   localparam int RL_LOIN      = 5;
   localparam int RL_CONIN     = 4;
   localparam int RL_OUTPORTIN = 3;
   localparam int RL_R15IN     = 2;
   localparam int RL_INCPC     = 1;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control-unit to datapath/memory signal bundle
interface control_sequencer_if;
   logic        stop;
   logic [31:0] ir;
   logic        con_ff;
   logic        mem_done;
   logic [7:0]  bus_drive;
   logic [5:0]  reg_sel;
   logic [12:0] reg_load;
   logic        mem_rd;
   logic        mem_wr;
   logic [5:0]  operation;
   logic        run;
   logic        illegal;

   modport master (
      input  stop, ir, con_ff, mem_done,
      output bus_drive, reg_sel, reg_load, mem_rd, mem_wr, operation, run, illegal
   );

   modport slave (
      output stop, ir, con_ff, mem_done,
      input  bus_drive, reg_sel, reg_load, mem_rd, mem_wr, operation, run, illegal
   );
endinterface

// File: rtl/opcode_class_decode.sv
// rtl/opcode_class_decode.sv - maps a 5-bit opcode onto its execute-sequence class
module opcode_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_t  op_class
);

   // Opcodes sharing a T3..T7 sequence collapse onto one class; anything above halt is illegal.
   always_comb begin
      op_class = CL_ILLEGAL;
      if (opcode == OP_LD)                              op_class = CL_LD;
      else if (opcode == OP_LDI)                        op_class = CL_LDI;
      else if (opcode == OP_ST)                         op_class = CL_ST;
      else if (opcode >= OP_ADD && opcode <= OP_ROL)    op_class = CL_ALU;
      else if (opcode >= OP_ADDI && opcode <= OP_ORI)   op_class = CL_IMM;
      else if (opcode == OP_MUL || opcode == OP_DIV)    op_class = CL_MULDIV;
      else if (opcode == OP_NEG || opcode == OP_NOT)    op_class = CL_NEGNOT;
      else if (opcode == OP_BR)                         op_class = CL_BR;
      else if (opcode == OP_JR)                         op_class = CL_JR;
      else if (opcode == OP_JAL)                        op_class = CL_JAL;
      else if (opcode == OP_IN)                         op_class = CL_IN;
      else if (opcode == OP_OUT)                        op_class = CL_OUT;
      else if (opcode == OP_MFHI)                       op_class = CL_MFHI;
      else if (opcode == OP_MFLO)                       op_class = CL_MFLO;
      else if (opcode == OP_NOP)                        op_class = CL_NOP;
      else if (opcode == OP_HALT)                       op_class = CL_HALT;
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state control unit for the Mini SRC single-bus CPU
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   control_sequencer_if.master cs
);

   state_t      state;
   op_class_t   cls;
   logic [4:0]  opcode;
   logic [5:0]  op_ext;
   logic [7:0]  bd;
   logic [5:0]  rs;
   logic [12:0] rl;
   logic        rd;
   logic        wr;
   logic [5:0]  op;
   logic        ill;
   logic        unused_ir;

   assign opcode    = cs.ir[31:27];
   assign op_ext    = {1'b0, opcode};
   assign unused_ir = ^cs.ir[26:0];

   opcode_class_decode u_decode (
      .opcode   (opcode),
      .op_class (cls)
   );

   // T-state sequencing; only mem_done (T1/T6/T7) and stop (T0) hold or divert the walk.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= ST_T0;
      end else begin
         case (state)
            ST_HALTED: state <= ST_HALTED;
            ST_T0:     state <= cs.stop ? ST_HALTED : ST_T1;
            ST_T1:     if (cs.mem_done) state <= ST_T2;
            ST_T2:     state <= ST_T3;
            ST_T3: begin
               case (cls)
                  CL_HALT: state <= ST_HALTED;
                  CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_ILLEGAL:
                     state <= ST_T0;
                  default: state <= ST_T4;
               endcase
            end
            ST_T4: begin
               case (cls)
                  CL_NEGNOT, CL_JAL: state <= ST_T0;
                  default:           state <= ST_T5;
               endcase
            end
            ST_T5: begin
               case (cls)
                  CL_ALU, CL_IMM, CL_LDI: state <= ST_T0;
                  default:                state <= ST_T6;
               endcase
            end
            ST_T6: begin
               case (cls)
                  CL_LD:   if (cs.mem_done) state <= ST_T7;
                  CL_ST:   state <= ST_T7;
                  default: state <= ST_T0;
               endcase
            end
            ST_T7: begin
               if (cls != CL_ST || cs.mem_done) state <= ST_T0;
            end
            default: state <= ST_T0;
         endcase
      end
   end

   // Strobe decode from state and opcode class; clr low or stop in T0 silences every strobe.
   always_comb begin
      bd  = '0;
      rs  = '0;
      rl  = '0;
      rd  = 1'b0;
      wr  = 1'b0;
      op  = '0;
      ill = 1'b0;
      case (state)
         ST_T0: begin
            if (!cs.stop) begin
               bd[BD_PC]    = 1'b1;
               rl[RL_MARIN] = 1'b1;
               rl[RL_INCPC] = 1'b1;
               rl[RL_ZIN]   = 1'b1;
            end
         end
         ST_T1: begin
            bd[BD_ZLO]   = 1'b1;
            rl[RL_PCIN]  = 1'b1;
            rl[RL_MDRIN] = 1'b1;
            rd           = 1'b1;
         end
         ST_T2: begin
            bd[BD_MDR]  = 1'b1;
            rl[RL_IRIN] = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CL_ALU, CL_IMM: begin
                  rs[RS_GRB] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_YIN] = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  rs[RS_GRB] = 1'b1; rs[RS_BAOUT] = 1'b1; rl[RL_YIN] = 1'b1;
               end
               CL_MULDIV: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_YIN] = 1'b1;
               end
               CL_NEGNOT: begin
                  rs[RS_GRB] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_ZIN] = 1'b1; op = op_ext;
               end
               CL_BR: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_CONIN] = 1'b1;
               end
               CL_JR: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_PCIN] = 1'b1;
               end
               CL_JAL: begin
                  bd[BD_PC] = 1'b1; rl[RL_R15IN] = 1'b1;
               end
               CL_IN: begin
                  bd[BD_INPORT] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_OUT: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_OUTPORTIN] = 1'b1;
               end
               CL_MFHI: begin
                  bd[BD_HI] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_MFLO: begin
                  bd[BD_LO] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_ILLEGAL: ill = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CL_ALU: begin
                  rs[RS_GRC] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_ZIN] = 1'b1; op = op_ext;
               end
               CL_IMM: begin
                  bd[BD_C] = 1'b1; rl[RL_ZIN] = 1'b1; op = op_ext;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  bd[BD_C] = 1'b1; rl[RL_ZIN] = 1'b1; op = {1'b0, OP_ADD};
               end
               CL_MULDIV: begin
                  rs[RS_GRB] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_ZIN] = 1'b1; op = op_ext;
               end
               CL_NEGNOT: begin
                  bd[BD_ZLO] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_BR: begin
                  bd[BD_PC] = 1'b1; rl[RL_YIN] = 1'b1;
               end
               CL_JAL: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_PCIN] = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CL_ALU, CL_IMM, CL_LDI: begin
                  bd[BD_ZLO] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_LD, CL_ST: begin
                  bd[BD_ZLO] = 1'b1; rl[RL_MARIN] = 1'b1;
               end
               CL_MULDIV: begin
                  bd[BD_ZLO] = 1'b1; rl[RL_LOIN] = 1'b1;
               end
               CL_BR: begin
                  bd[BD_C] = 1'b1; rl[RL_ZIN] = 1'b1; op = {1'b0, OP_ADD};
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CL_LD: begin
                  rd = 1'b1; rl[RL_MDRIN] = 1'b1;
               end
               CL_ST: begin
                  rs[RS_GRA] = 1'b1; rs[RS_ROUT] = 1'b1; rl[RL_MDRIN] = 1'b1;
               end
               CL_MULDIV: begin
                  bd[BD_ZHI] = 1'b1; rl[RL_HIIN] = 1'b1;
               end
               CL_BR: begin
                  bd[BD_ZLO] = 1'b1; rl[RL_PCIN] = cs.con_ff;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CL_LD: begin
                  bd[BD_MDR] = 1'b1; rs[RS_GRA] = 1'b1; rs[RS_RIN] = 1'b1;
               end
               CL_ST: wr = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
      if (!clr) begin
         bd  = '0;
         rs  = '0;
         rl  = '0;
         rd  = 1'b0;
         wr  = 1'b0;
         op  = '0;
         ill = 1'b0;
      end
   end

   assign cs.bus_drive = bd;
   assign cs.reg_sel   = rs;
   assign cs.reg_load  = rl;
   assign cs.mem_rd    = rd;
   assign cs.mem_wr    = wr;
   assign cs.operation = op;
   assign cs.illegal   = ill;
   assign cs.run       = (state != ST_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
module tb_control_sequencer;

   logic clk = 1'b0;
   logic clr;

   control_sequencer_if cs_if ();

   control_sequencer dut (
      .clk (clk),
      .clr (clr),
      .cs  (cs_if)
   );

   always #5 clk = ~clk;

   localparam logic [7:0] PCOUT = 8'h80, ZHI = 8'h40, ZLO = 8'h20, MDROUT = 8'h10;
   localparam logic [7:0] HIOUT = 8'h08, LOOUT = 8'h04, INPOUT = 8'h02, COUT = 8'h01;
   localparam logic [5:0] GRA = 6'h20, GRB = 6'h10, GRC = 6'h08, RIN = 6'h04, ROUT = 6'h02, BAOUT = 6'h01;
   localparam logic [12:0] MARIN = 13'h1000, PCIN = 13'h0800, MDRIN = 13'h0400, IRIN = 13'h0200;
   localparam logic [12:0] YIN = 13'h0100, ZIN = 13'h0080, HIIN = 13'h0040, LOIN = 13'h0020;
   localparam logic [12:0] CONIN = 13'h0010, OUTIN = 13'h0008, R15IN = 13'h0004, INCPC = 13'h0002;
   localparam logic [7:0]  B0 = 8'h00;
   localparam logic [5:0]  S0 = 6'h00;
   localparam logic [12:0] L0 = 13'h0000;

   typedef struct {
      logic [36:0] out;
      logic        md;
      logic        stp;
      logic [31:0] ir;
      logic        con;
   } step_t;

   step_t       exp_q[$];
   logic [36:0] obs_q[$];
   logic [31:0] cur_ir;
   logic        cur_con;
   int          total = 0;
   int          bad = 0;

   // observed/expected layout: bus[36:29] sel[28:23] load[22:10] rd[9] wr[8] op[7:2] ill[1] run[0]
   function automatic logic [36:0] mk(input logic [7:0] b, input logic [5:0] s, input logic [12:0] l,
                                      input logic rd, input logic wr, input logic [5:0] op,
                                      input logic ill, input logic rn);
      return {b, s, l, rd, wr, op, ill, rn};
   endfunction

   function automatic logic [36:0] m3(input logic [7:0] b, input logic [5:0] s, input logic [12:0] l);
      return mk(b, s, l, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
   endfunction

   function automatic logic [36:0] mo(input logic [7:0] b, input logic [5:0] s, input logic [12:0] l,
                                      input int op);
      return mk(b, s, l, 1'b0, 1'b0, 6'(op), 1'b0, 1'b1);
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(1, 0));
   endfunction

   function automatic logic [36:0] sample();
      return {cs_if.bus_drive, cs_if.reg_sel, cs_if.reg_load, cs_if.mem_rd, cs_if.mem_wr,
              cs_if.operation, cs_if.illegal, cs_if.run};
   endfunction

   task automatic pushx(input logic [36:0] o, input logic md, input logic stp);
      step_t s;
      s.out = o; s.md = md; s.stp = stp; s.ir = cur_ir; s.con = cur_con;
      exp_q.push_back(s);
   endtask

   task automatic push(input logic [36:0] o);
      pushx(o, rbit(), rbit());
   endtask

   // A memory step repeats while the RAM is busy; mem_done rises on its last cycle only.
   task automatic push_wait(input logic [36:0] o, input int w);
      for (int k = 0; k < w; k++) pushx(o, 1'b0, rbit());
      pushx(o, 1'b1, rbit());
   endtask

   task automatic halted_steps(input int n);
      for (int k = 0; k < n; k++) push(mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0));
   endtask

   // Reference: the per-cycle strobe list of one instruction, straight from the instruction tables.
   task automatic build(input logic [31:0] i_ir, input logic con, input int w1, input int w2);
      int o;
      cur_ir = i_ir; cur_con = con;
      o = int'(i_ir[31:27]);
      pushx(m3(PCOUT, S0, MARIN | ZIN | INCPC), rbit(), 1'b0);
      push_wait(mk(ZLO, S0, PCIN | MDRIN, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1), w1);
      push(m3(MDROUT, S0, IRIN));
      if (o <= 2) begin
         push(m3(B0, GRB | BAOUT, YIN));
         push(mo(COUT, S0, ZIN, 3));
         if (o == 1) push(m3(ZLO, GRA | RIN, L0));
         else begin
            push(m3(ZLO, S0, MARIN));
            if (o == 0) begin
               push_wait(mk(B0, S0, MDRIN, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1), w2);
               push(m3(MDROUT, GRA | RIN, L0));
            end else begin
               push(m3(B0, GRA | ROUT, MDRIN));
               push_wait(mk(B0, S0, L0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1), w2);
            end
         end
      end else if (o <= 14) begin
         push(m3(B0, GRB | ROUT, YIN));
         if (o <= 11) push(mo(B0, GRC | ROUT, ZIN, o));
         else         push(mo(COUT, S0, ZIN, o));
         push(m3(ZLO, GRA | RIN, L0));
      end else if (o <= 16) begin
         push(m3(B0, GRA | ROUT, YIN));
         push(mo(B0, GRB | ROUT, ZIN, o));
         push(m3(ZLO, S0, LOIN));
         push(m3(ZHI, S0, HIIN));
      end else if (o <= 18) begin
         push(mo(B0, GRB | ROUT, ZIN, o));
         push(m3(ZLO, GRA | RIN, L0));
      end else if (o == 19) begin
         push(m3(B0, GRA | ROUT, CONIN));
         push(m3(PCOUT, S0, YIN));
         push(mo(COUT, S0, ZIN, 3));
         push(m3(ZLO, S0, con ? PCIN : L0));
      end else if (o == 20) push(m3(B0, GRA | ROUT, PCIN));
      else if (o == 21) begin
         push(m3(PCOUT, S0, R15IN));
         push(m3(B0, GRA | ROUT, PCIN));
      end
      else if (o == 22) push(m3(INPOUT, GRA | RIN, L0));
      else if (o == 23) push(m3(B0, GRA | ROUT, OUTIN));
      else if (o == 24) push(m3(HIOUT, GRA | RIN, L0));
      else if (o == 25) push(m3(LOOUT, GRA | RIN, L0));
      else if (o <= 27) push(m3(B0, S0, L0));
      else push(mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1));
   endtask

   // Drives one queued step per cycle (called just after a falling edge) and records the outputs.
   task automatic play();
      obs_q.delete();
      foreach (exp_q[i]) begin
         cs_if.ir       = exp_q[i].ir;
         cs_if.con_ff   = exp_q[i].con;
         cs_if.mem_done = exp_q[i].md;
         cs_if.stop     = exp_q[i].stp;
         #1;
         obs_q.push_back(sample());
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0; cs_if.stop = 1'b0; cs_if.mem_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      clr = 1'b0; cs_if.stop = 1'b0; cs_if.mem_done = 1'b0; cs_if.ir = 32'h0; cs_if.con_ff = 1'b0;
      @(negedge clk); #1;
      total++;
      if (sample() !== mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1)) begin
         bad++; $display("FAIL reset_state got=%h want=%h", sample(), mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1));
      end
      clr = 1'b1; #1;
      total++;
      if (sample() !== m3(PCOUT, S0, MARIN | ZIN | INCPC)) begin
         bad++; $display("FAIL reset_t0 got=%h want=%h", sample(), m3(PCOUT, S0, MARIN | ZIN | INCPC));
      end
      cs_if.stop = 1'b1; #1;
      total++;
      if (sample() !== mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1)) begin
         bad++; $display("FAIL t0_stop_quiet got=%h want=%h", sample(), mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1));
      end
      @(negedge clk); #1;
      total++;
      if (cs_if.run !== 1'b0) begin
         bad++; $display("FAIL t0_stop_halts run=%b want=0", cs_if.run);
      end
   endtask

   task automatic test_add();
      do_reset();
      build(32'h19880000, 1'b0, 0, 0);
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL add step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      total++;
      if (obs_q[4][22:10] !== ZIN || obs_q[4][28:23] !== (GRC | ROUT)) begin
         bad++; $display("FAIL add_cycle5 load=%h sel=%h want load=%h sel=%h", obs_q[4][22:10], obs_q[4][28:23], ZIN, GRC | ROUT);
      end
      total++;
      if (obs_q[5][28:23] !== (GRA | RIN) || obs_q[6][22:10] !== (MARIN | ZIN | INCPC)) begin
         bad++; $display("FAIL add_cycle6_then_t0 sel=%h next_load=%h", obs_q[5][28:23], obs_q[6][22:10]);
      end
   endtask

   task automatic test_ld_wait();
      do_reset();
      build(32'h00900054, 1'b0, 0, 2);
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL ld step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      total++;
      if (obs_q[8][22:10] !== MDRIN || obs_q[9][28:23] !== (GRA | RIN) || obs_q[10][22:10] !== (MARIN | ZIN | INCPC)) begin
         bad++; $display("FAIL ld_10_cycles t6_load=%h t7_sel=%h next_load=%h", obs_q[8][22:10], obs_q[9][28:23], obs_q[10][22:10]);
      end
   endtask

   task automatic test_br();
      do_reset();
      build(32'h98800000, 1'b0, 0, 0);
      build(32'h98800000, 1'b1, 0, 0);
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL br step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      total++;
      if (obs_q[6][22:10] !== L0 || obs_q[13][22:10] !== PCIN || obs_q[6][36:29] !== ZLO || obs_q[13][36:29] !== ZLO) begin
         bad++; $display("FAIL br_t6 con0_load=%h con1_load=%h bus=%h/%h", obs_q[6][22:10], obs_q[13][22:10], obs_q[6][36:29], obs_q[13][36:29]);
      end
   endtask

   task automatic test_mul();
      do_reset();
      build(32'h78880000, 1'b0, 1, 0);
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL mul step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      total++;
      if (obs_q[6][22:10] !== LOIN || obs_q[7][22:10] !== HIIN) begin
         bad++; $display("FAIL mul_lo_hi t5=%h t6=%h", obs_q[6][22:10], obs_q[7][22:10]);
      end
   endtask

   task automatic test_stop_halt();
      do_reset();
      build(32'h19880000, 1'b0, 0, 0);
      exp_q[4].stp = 1'b1;
      pushx(mk(B0, S0, L0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1), 1'b0, 1'b1);
      halted_steps(4);
      build({5'b11011, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out && i < 11) begin
            bad++; $display("FAIL stop step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      cs_if.stop = 1'b0;
      clr = 1'b0;
      @(negedge clk); #1;
      total++;
      if (cs_if.run !== 1'b1 || cs_if.reg_load !== L0) begin
         bad++; $display("FAIL halted_clr run=%b load=%h want run=1 load=0", cs_if.run, cs_if.reg_load);
      end
      clr = 1'b1; #1;
      total++;
      if (cs_if.reg_load !== (MARIN | ZIN | INCPC)) begin
         bad++; $display("FAIL halted_clr_t0 load=%h want=%h", cs_if.reg_load, MARIN | ZIN | INCPC);
      end
   endtask

   task automatic test_halt_instr();
      do_reset();
      build({5'b11011, 27'h5}, 1'b0, 2, 0);
      halted_steps(3);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL halt step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
   endtask

   task automatic test_illegal_clr();
      do_reset();
      build(32'hF8000000, 1'b0, 0, 0);
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL illegal step %0d got=%h want=%h", i, obs_q[i], exp_q[i].out);
         end
      end
      do_reset();
      cs_if.mem_done = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      total++;
      if (cs_if.mem_rd !== 1'b1) begin
         bad++; $display("FAIL t1_wait_rd mem_rd=%b want=1", cs_if.mem_rd);
      end
      clr = 1'b0;
      @(negedge clk); #1;
      total++;
      if (cs_if.mem_rd !== 1'b0 || cs_if.bus_drive !== B0) begin
         bad++; $display("FAIL t1_wait_clr mem_rd=%b bus=%h want 0/00", cs_if.mem_rd, cs_if.bus_drive);
      end
      clr = 1'b1; #1;
      total++;
      if (cs_if.reg_load !== (MARIN | ZIN | INCPC)) begin
         bad++; $display("FAIL t1_wait_refetch load=%h want=%h", cs_if.reg_load, MARIN | ZIN | INCPC);
      end
   endtask

   task automatic test_back_to_back();
      int opc;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         opc = int'($urandom_range(31, 0));
         if (opc == 27) opc = 26;
         build({5'(opc), 27'($urandom)}, rbit(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end
      build({5'b11010, 27'h0}, 1'b0, 0, 0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i].out) begin
            bad++; $display("FAIL random step %0d ir=%h got=%h want=%h", i, exp_q[i].ir, obs_q[i], exp_q[i].out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ld_wait();
      test_br();
      test_mul();
      test_stop_halt();
      test_halt_instr();
      test_illegal_clr();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
